// File: rtl/sram_slot_arbiter.sv
// sram_slot_arbiter: shares one asynchronous SRAM between the delay client (0)
// and the loop client (1) inside each audio sample slot. A slot opens on
// i_frame_start. Client 0 goes first, then client 1. Each grant is followed by a
// one-cycle bus-turnaround gap in which no write is driven.
// Optional feature: define SRAM_ARB_TIMEOUT_EN to add a per-grant watchdog.
// The watchdog forces a release after TIMEOUT cycles and sets the sticky
// o_timeout output.
module sram_slot_arbiter #(
    parameter int TIMEOUT = 24
) (
    input  logic        i_AUD_BCLK,
    input  logic        i_rst_n,
    input  logic        i_frame_start,
    input  logic        i_en0,
    input  logic        i_en1,
    input  logic        i_done0,
    input  logic        i_done1,
    input  logic [19:0] i_addr0,
    input  logic [19:0] i_addr1,
    input  logic        i_we_n0,
    input  logic        i_we_n1,
    input  logic [15:0] i_wdata0,
    input  logic [15:0] i_wdata1,
    output logic        o_gnt0,
    output logic        o_gnt1,
    output logic [19:0] o_sram_addr,
    output logic        o_sram_we_n,
    output logic [15:0] o_sram_wdata,
    output logic        o_sram_dq_oe,
    output logic        o_busy,
    output logic        o_overrun,
    output logic [7:0]  o_overrun_cnt
`ifdef SRAM_ARB_TIMEOUT_EN
    ,
    output logic        o_timeout
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        GNT0,
        GAP0,
        GNT1,
        GAP1
    } state_t;

    state_t state;
    state_t state_next;
    logic   timeout_hit;
    logic   frame_overrun;

    // TIMEOUT must fit the 8-bit grant counter and leave at least one full grant cycle
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("sram_slot_arbiter: TIMEOUT must be in 2..255");
    end

    assign frame_overrun = i_frame_start && (state != IDLE);

`ifdef SRAM_ARB_TIMEOUT_EN
    logic [7:0] grant_cnt;
    logic       grant_active;
    logic       done_cur;

    assign grant_active = (state == GNT0) || (state == GNT1);
    assign done_cur     = (state == GNT0) ? i_done0 : i_done1;
    assign timeout_hit  = grant_active && (grant_cnt == 8'(TIMEOUT - 1));

    // Count cycles spent in the current grant; every grant is entered from a non-grant state, so it starts at zero
    always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            grant_cnt <= 8'd0;
            o_timeout <= 1'b0;
        end else begin
            grant_cnt <= grant_active ? grant_cnt + 8'd1 : 8'd0;
            if (timeout_hit && !done_cur) begin
                o_timeout <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Slot sequencer state register
    always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decisions use the enables as they are when each decision is made
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_frame_start) begin
                    if (i_en0) begin
                        state_next = GNT0;
                    end else if (i_en1) begin
                        state_next = GNT1;
                    end
                end
            end
            GNT0: if (i_done0 || timeout_hit) state_next = GAP0;
            GAP0: state_next = i_en1 ? GNT1 : IDLE;
            GNT1: if (i_done1 || timeout_hit) state_next = GAP1;
            GAP1: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The SRAM bus follows the granted client; outside a grant it is parked with no write and DQ released
    always_comb begin
        o_sram_addr  = 20'd0;
        o_sram_we_n  = 1'b1;
        o_sram_wdata = 16'd0;
        o_sram_dq_oe = 1'b0;
        case (state)
            GNT0: begin
                o_sram_addr  = i_addr0;
                o_sram_we_n  = i_we_n0;
                o_sram_wdata = i_wdata0;
                o_sram_dq_oe = ~i_we_n0;
            end
            GNT1: begin
                o_sram_addr  = i_addr1;
                o_sram_we_n  = i_we_n1;
                o_sram_wdata = i_wdata1;
                o_sram_dq_oe = ~i_we_n1;
            end
            default: begin
                o_sram_addr  = 20'd0;
                o_sram_we_n  = 1'b1;
                o_sram_wdata = 16'd0;
                o_sram_dq_oe = 1'b0;
            end
        endcase
    end

    assign o_gnt0 = (state == GNT0);
    assign o_gnt1 = (state == GNT1);
    assign o_busy = (state != IDLE);

    // Flag frame starts that arrive before the previous slot finished; the counter saturates instead of wrapping
    always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_overrun     <= 1'b0;
            o_overrun_cnt <= 8'd0;
        end else begin
            o_overrun <= frame_overrun;
            if (frame_overrun && (o_overrun_cnt != 8'hFF)) begin
                o_overrun_cnt <= o_overrun_cnt + 8'd1;
            end
        end
    end

endmodule
